// File: rtl/prog_mem_if.sv
// System-side request bus of prog_mem_arbiter.
// Each field is packed per port, with port 0 in the LSBs.
interface prog_mem_if #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [NUM_PORTS-1:0]            port_req;
   logic [NUM_PORTS-1:0]            port_we;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
   logic [NUM_PORTS*NB-1:0]         port_be;
   logic [NUM_PORTS-1:0]            port_ack;
   logic [DATA_WIDTH-1:0]           port_rdata;

   modport master (
      output port_req, port_we, port_addr, port_wdata, port_be,
      input  port_ack, port_rdata
   );

   modport slave (
      input  port_req, port_we, port_addr, port_wdata, port_be,
      output port_ack, port_rdata
   );
endinterface

// File: rtl/prog_mem_arbiter.sv
// Program/data memory shared by NUM_PORTS round-robin system ports and a debug port.
// The DRAIN/DEBUG/RELEASE sequence holds the CPU in reset while debug owns the memory.
// Optional: define PROG_MEM_PARITY_EN to add per-byte even parity and a sticky error report.
module prog_mem_arbiter #(
   parameter int unsigned NUM_PORTS     = 2,
   parameter int unsigned ADDR_WIDTH    = 10,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned RELEASE_DELAY = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   prog_mem_if.slave             bus,
   input  logic                  dbg_en,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic                  dbg_ack,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_active,
`ifdef PROG_MEM_PARITY_EN
   output logic                  cpu_hold,
   output logic                  parity_err,
   output logic [ADDR_WIDTH-1:0] parity_err_addr
`else
   output logic                  cpu_hold
`endif
);
   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned CW    = $clog2(RELEASE_DELAY + 1);

   typedef enum logic [1:0] {ST_NORMAL, ST_DRAIN, ST_DEBUG, ST_RELEASE} state_t;

   state_t                state;
   logic [PW-1:0]         rr_ptr;
   logic [CW-1:0]         rel_cnt;
   logic [NUM_PORTS-1:0]  port_ack_q;
   logic [DATA_WIDTH-1:0] port_rdata_q;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [NUM_PORTS-1:0]  eligible_c;
   logic [PW:0]           scan_c;
   logic                  grant_vld_c;
   logic [PW-1:0]         grant_idx_c;

   logic                  mem_en_c;
   logic                  mem_we_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;
   logic [NB-1:0]         mem_be_c;
   logic [DATA_WIDTH-1:0] rd_word_c;

   assign bus.port_ack   = port_ack_q;
   assign bus.port_rdata = port_rdata_q;

   // A port that is seeing its ack this cycle already had its request served.
   assign eligible_c = bus.port_req & ~port_ack_q;

   // Round-robin search starting at rr_ptr.
   always_comb begin
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      scan_c      = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         scan_c = {1'b0, rr_ptr} + (PW+1)'(i);
         if (scan_c >= (PW+1)'(NUM_PORTS)) begin
            scan_c = scan_c - (PW+1)'(NUM_PORTS);
         end
         if (!grant_vld_c && eligible_c[PW'(scan_c)]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = PW'(scan_c);
         end
      end
   end

   // Single memory port: system grant in NORMAL, debug access in DEBUG; nothing under reset.
   always_comb begin
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      mem_be_c    = '0;
      if (!rst) begin
         if (state == ST_NORMAL && grant_vld_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.port_we[grant_idx_c];
            mem_addr_c  = bus.port_addr[32'(grant_idx_c) * ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_c = bus.port_wdata[32'(grant_idx_c) * DATA_WIDTH +: DATA_WIDTH];
            mem_be_c    = bus.port_be[32'(grant_idx_c) * NB +: NB];
         end else if (state == ST_DEBUG && dbg_req) begin
            mem_en_c    = 1'b1;
            mem_we_c    = dbg_we;
            mem_addr_c  = dbg_addr;
            mem_wdata_c = dbg_wdata;
            mem_be_c    = '1;
         end
      end
   end

   assign rd_word_c = mem[mem_addr_c];

`ifdef PROG_MEM_PARITY_EN
   logic [NB-1:0] mem_par [DEPTH];
   logic [NB-1:0] par_calc_c;
   logic          par_bad_c;
`endif

   // Memory array is never reset.
   always_ff @(posedge clk) begin
      if (mem_en_c && mem_we_c) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (mem_be_c[b]) begin
               mem[mem_addr_c][b*8 +: 8] <= mem_wdata_c[b*8 +: 8];
`ifdef PROG_MEM_PARITY_EN
               mem_par[mem_addr_c][b] <= ^mem_wdata_c[b*8 +: 8];
`endif
            end
         end
      end
   end

`ifdef PROG_MEM_PARITY_EN
   always_comb begin
      par_calc_c = '0;
      for (int unsigned b = 0; b < NB; b++) begin
         par_calc_c[b] = ^rd_word_c[b*8 +: 8];
      end
   end

   assign par_bad_c = mem_en_c && !mem_we_c && (par_calc_c != mem_par[mem_addr_c]);

   // Sticky error; only the first failing address is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err      <= 1'b0;
         parity_err_addr <= '0;
      end else if (par_bad_c && !parity_err) begin
         parity_err      <= 1'b1;
         parity_err_addr <= mem_addr_c;
      end
   end
`endif

   // Mode sequencing, arbitration pointer and registered responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_NORMAL;
         rr_ptr       <= '0;
         rel_cnt      <= '0;
         port_ack_q   <= '0;
         port_rdata_q <= '0;
         dbg_ack      <= 1'b0;
         dbg_rdata    <= '0;
         dbg_active   <= 1'b0;
         cpu_hold     <= 1'b0;
      end else begin
         port_ack_q <= '0;
         dbg_ack    <= 1'b0;
         case (state)
            ST_NORMAL: begin
               if (mem_en_c) begin
                  port_ack_q[grant_idx_c] <= 1'b1;
                  rr_ptr <= (grant_idx_c == PW'(NUM_PORTS - 1)) ? '0 : grant_idx_c + PW'(1);
                  if (!mem_we_c) begin
                     port_rdata_q <= rd_word_c;
                  end
               end
               if (dbg_en) begin
                  state    <= ST_DRAIN;
                  cpu_hold <= 1'b1;
               end
            end
            ST_DRAIN: begin
               state      <= ST_DEBUG;
               dbg_active <= 1'b1;
            end
            ST_DEBUG: begin
               if (mem_en_c) begin
                  dbg_ack <= 1'b1;
                  if (!mem_we_c) begin
                     dbg_rdata <= rd_word_c;
                  end
               end
               if (!dbg_en) begin
                  state      <= ST_RELEASE;
                  dbg_active <= 1'b0;
                  rel_cnt    <= '0;
               end
            end
            ST_RELEASE: begin
               if (dbg_en) begin
                  state      <= ST_DEBUG;
                  dbg_active <= 1'b1;
                  rel_cnt    <= '0;
               end else if (rel_cnt == CW'(RELEASE_DELAY - 1)) begin
                  state    <= ST_NORMAL;
                  cpu_hold <= 1'b0;
                  rel_cnt  <= '0;
               end else begin
                  rel_cnt <= rel_cnt + CW'(1);
               end
            end
            default: state <= ST_NORMAL;
         endcase
      end
   end
endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Randomised self-checking bench for prog_mem_arbiter against a word-array reference model.
module tb_prog_mem_arbiter;
   localparam int NP = 2;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prog_mem_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) pif ();

   logic          dbg_en, dbg_req, dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          dbg_ack, dbg_active, cpu_hold;
`ifdef PROG_MEM_PARITY_EN
   logic          parity_err;
   logic [AW-1:0] parity_err_addr;
`endif

   prog_mem_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RELEASE_DELAY(4)
   ) dut (
      .clk(clk), .rst(rst), .bus(pif.slave),
      .dbg_en(dbg_en), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .dbg_active(dbg_active),
`ifdef PROG_MEM_PARITY_EN
      .parity_err(parity_err), .parity_err_addr(parity_err_addr),
`endif
      .cpu_hold(cpu_hold)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain word array plus the arbitration pointer and visible responses.
   logic [DW-1:0] mem_m [1 << AW];
   int            rr_m;
   logic [NP-1:0] ack_m;
   logic [DW-1:0] rd_m, dbg_rd_m;
   logic [DW-1:0] rd;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                           input logic [NB-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < NB; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   function automatic int pick(input logic [NP-1:0] elig, input int start);
      for (int i = 0; i < NP; i++) begin
         int k;
         k = (start + i) % NP;
         if (elig[k]) return k;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int k, input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [NB-1:0] be);
      pif.port_req[k]            = req;
      pif.port_we[k]             = we;
      pif.port_addr[k*AW +: AW]  = a;
      pif.port_wdata[k*DW +: DW] = d;
      pif.port_be[k*NB +: NB]    = be;
   endtask

   // One clock of system traffic, predicted by the model and then compared.
   task automatic cycle_normal(input string tag);
      logic [NP-1:0] exp_ack;
      logic [DW-1:0] exp_rd;
      logic [AW-1:0] a;
      logic          is_rd;
      int            g;
      exp_ack = '0;
      exp_rd  = rd_m;
      is_rd   = 1'b0;
      g = pick(pif.port_req & ~ack_m, rr_m);
      if (g >= 0) begin
         exp_ack[g] = 1'b1;
         rr_m = (g + 1) % NP;
         a = pif.port_addr[g*AW +: AW];
         if (pif.port_we[g])
            mem_m[a] = merge(mem_m[a], pif.port_wdata[g*DW +: DW], pif.port_be[g*NB +: NB]);
         else begin
            exp_rd = mem_m[a];
            is_rd  = 1'b1;
         end
      end
      tick();
      check_eq({tag, "_ack"}, 64'(pif.port_ack), 64'(exp_ack));
      if (is_rd) check_eq({tag, "_rdata"}, 64'(pif.port_rdata), 64'(exp_rd));
      check_eq({tag, "_dbg_ack"}, 64'(dbg_ack), 64'd0);
      ack_m = exp_ack;
      rd_m  = exp_rd;
   endtask

   task automatic port_op(input int k, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [NB-1:0] be,
                          output logic [DW-1:0] rdata);
      logic got;
      got = 1'b0;
      set_port(k, 1'b1, we, a, d, be);
      for (int i = 0; i < 4 && !got; i++) begin
         cycle_normal("op");
         if (pif.port_ack[k]) got = 1'b1;
      end
      check_eq("op_acked", 64'(got), 64'd1);
      rdata = pif.port_rdata;
      pif.port_req[k] = 1'b0;
   endtask

   task automatic dbg_cycle(input string tag, input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [DW-1:0] exp_rd;
      dbg_req   = req;
      dbg_we    = we;
      dbg_addr  = a;
      dbg_wdata = d;
      exp_rd    = dbg_rd_m;
      if (req) begin
         if (we) mem_m[a] = d;
         else exp_rd = mem_m[a];
      end
      tick();
      check_eq({tag, "_dbg_ack"}, 64'(dbg_ack), 64'(req));
      if (req && !we) check_eq({tag, "_dbg_rdata"}, 64'(dbg_rdata), 64'(exp_rd));
      check_eq({tag, "_port_ack"}, 64'(pif.port_ack), 64'd0);
      dbg_rd_m = exp_rd;
      dbg_req  = 1'b0;
   endtask

   task automatic check_mode(input string tag, input logic hold, input logic active);
      check_eq({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(hold));
      check_eq({tag, "_dbg_active"}, 64'(dbg_active), 64'(active));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_port_ack"}, 64'(pif.port_ack), 64'd0);
      check_eq({tag, "_port_rdata"}, 64'(pif.port_rdata), 64'd0);
      check_eq({tag, "_dbg_ack"}, 64'(dbg_ack), 64'd0);
      check_eq({tag, "_dbg_rdata"}, 64'(dbg_rdata), 64'd0);
      check_mode(tag, 1'b0, 1'b0);
   endtask

   // Random requesters: a port keeps its request until acked, then may issue a new one.
   task automatic rand_normal(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         for (int k = 0; k < NP; k++) begin
            if (!pif.port_req[k] || ack_m[k]) begin
               if ($urandom_range(9) < 6)
                  set_port(k, 1'b1, 1'($urandom_range(1)), AW'(16 + $urandom_range(15)),
                           $urandom, NB'($urandom_range(15)));
               else
                  pif.port_req[k] = 1'b0;
            end
         end
         dbg_req  = 1'($urandom_range(1));
         dbg_we   = 1'($urandom_range(1));
         dbg_addr = AW'($urandom_range(31));
         cycle_normal("rnd");
      end
      dbg_req      = 1'b0;
      pif.port_req = '0;
      cycle_normal("idle1");
      cycle_normal("idle2");
   endtask

   initial begin
      rst = 1'b1;
      dbg_en = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      pif.port_req = '0; pif.port_we = '0; pif.port_addr = '0;
      pif.port_wdata = '0; pif.port_be = '0;
      tick();
      tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      rr_m = 0; ack_m = '0; rd_m = '0; dbg_rd_m = '0;

      // Preload; the final access by port 1 leaves the pointer at port 0.
      for (int a = 0; a < 32; a++) begin
         if (a != 3)
            port_op(0, 1'b1, AW'(a), (a == 5) ? 32'hA5A5A5A5 : $urandom, 4'hF, rd);
      end
      port_op(1, 1'b1, AW'(3), 32'h11223344, 4'hF, rd);

      // Both ports read addr 5 continuously.
      set_port(0, 1'b1, 1'b0, AW'(5), '0, '0);
      set_port(1, 1'b1, 1'b0, AW'(5), '0, '0);
      cycle_normal("t1c1");
      check_eq("t1_ack_c1", 64'(pif.port_ack), 64'b01);
      check_eq("t1_rdata_c1", 64'(pif.port_rdata), 64'hA5A5A5A5);
      cycle_normal("t1c2");
      check_eq("t1_ack_c2", 64'(pif.port_ack), 64'b10);
      cycle_normal("t1c3");
      check_eq("t1_ack_c3", 64'(pif.port_ack), 64'b01);
      pif.port_req = '0;

      // Partial-byte write merge.
      port_op(1, 1'b1, AW'(3), 32'hDEADBEEF, 4'b0011, rd);
      port_op(0, 1'b0, AW'(3), '0, '0, rd);
      check_eq("t2_merge", 64'(rd), 64'h1122BEEF);

      rand_normal(300);

      // Debug entry with a read granted on the same edge.
      set_port(0, 1'b1, 1'b0, AW'(5), '0, '0);
      dbg_en = 1'b1;
      cycle_normal("t3");
      check_eq("t3_ack", 64'(pif.port_ack), 64'b01);
      check_eq("t3_rdata", 64'(pif.port_rdata), 64'hA5A5A5A5);
      check_mode("t3_drain", 1'b1, 1'b0);
      tick();
      check_eq("t3_no_ack", 64'(pif.port_ack), 64'd0);
      check_mode("t3_debug", 1'b1, 1'b1);
      ack_m = '0;

      dbg_cycle("t4w", 1'b1, 1'b1, AW'(10'h3FF), 32'h12345678);
      dbg_cycle("t4r", 1'b1, 1'b0, AW'(10'h3FF), '0);
      check_eq("t4_rdata", 64'(dbg_rdata), 64'h12345678);
      for (int c = 0; c < 60; c++) begin
         pif.port_req[1] = 1'($urandom_range(1));
         dbg_cycle("dbg_rnd", 1'($urandom_range(1)), 1'($urandom_range(1)),
                   AW'(16 + $urandom_range(15)), $urandom);
         check_mode("dbg_rnd", 1'b1, 1'b1);
      end
      pif.port_req[1] = 1'b0;

      // Leave debug with a final read; pending port 0 waits out the release delay.
      dbg_en = 1'b0;
      dbg_cycle("t5", 1'b1, 1'b0, AW'(10'h3FF), '0);
      check_eq("t5_rdata", 64'(dbg_rdata), 64'h12345678);
      check_mode("t5_rel0", 1'b1, 1'b0);
      for (int i = 1; i < 4; i++) begin
         tick();
         check_mode("t5_rel", 1'b1, 1'b0);
         check_eq("t5_rel_ack", 64'(pif.port_ack), 64'd0);
      end
      tick();
      check_mode("t5_normal", 1'b0, 1'b0);
      check_eq("t5_normal_ack", 64'(pif.port_ack), 64'd0);
      cycle_normal("t5g");
      check_eq("t5_grant", 64'(pif.port_ack), 64'b01);
      check_eq("t5_grant_rdata", 64'(pif.port_rdata), 64'hA5A5A5A5);
      pif.port_req[0] = 1'b0;
      cycle_normal("t5d");

      // Re-entering debug from RELEASE skips DRAIN and restarts the delay.
      dbg_en = 1'b1;
      tick(); check_mode("re_drain", 1'b1, 1'b0);
      tick(); check_mode("re_debug", 1'b1, 1'b1);
      dbg_en = 1'b0;
      tick(); check_mode("re_rel0", 1'b1, 1'b0);
      tick(); check_mode("re_rel1", 1'b1, 1'b0);
      dbg_en = 1'b1;
      tick(); check_mode("re_direct", 1'b1, 1'b1);
      dbg_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_mode("re_rel", 1'b1, 1'b0);
      end
      tick();
      check_mode("re_normal", 1'b0, 1'b0);
      ack_m = '0;

      rand_normal(100);

      // Reset on the grant edge drops the write.
      port_op(0, 1'b1, AW'(7), 32'hCAFEF00D, 4'hF, rd);
      set_port(0, 1'b1, 1'b1, AW'(7), 32'h0BADBEEF, 4'hF);
      rst = 1'b1;
      tick();
      check_reset_outputs("t6_rst");
      rst = 1'b0;
      pif.port_req = '0;
      tick();
      check_eq("t6_no_ack", 64'(pif.port_ack), 64'd0);
      rr_m = 0; ack_m = '0; rd_m = '0; dbg_rd_m = '0;
      port_op(1, 1'b0, AW'(7), '0, '0, rd);
      check_eq("t6_retained", 64'(rd), 64'hCAFEF00D);

      // Write then read of the same address from different ports on consecutive cycles.
      set_port(0, 1'b1, 1'b1, AW'(9), 32'h13572468, 4'hF);
      set_port(1, 1'b1, 1'b0, AW'(9), '0, '0);
      cycle_normal("hz1");
      check_eq("hz_write_ack", 64'(pif.port_ack), 64'b01);
      pif.port_req[0] = 1'b0;
      cycle_normal("hz2");
      check_eq("hz_read_ack", 64'(pif.port_ack), 64'b10);
      check_eq("hz_read_data", 64'(pif.port_rdata), 64'h13572468);
      pif.port_req[1] = 1'b0;
      cycle_normal("end");

`ifdef PROG_MEM_PARITY_EN
      check_eq("parity_err", 64'(parity_err), 64'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_mem_arbiter.md
Name: prog_mem_arbiter

Overview:
Multi-port program/data memory with built-in arbitration between NUM_PORTS system requesters and one debug (JTAG programming) port. It is the generalised successor of the single-port memory-mux arrangement. It adds byte-enable writes, round-robin arbitration, a req/ack handshake on every port, and a drain/debug/release state machine that quiesces system traffic and holds the CPU in reset while the debug port owns the memory.

Parameters:
NUM_PORTS, 2, number of system requester ports (1..8)
ADDR_WIDTH, 10, word address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width; multiple of 8; NB = DATA_WIDTH/8 byte lanes
RELEASE_DELAY, 4, cycles CPU reset stays asserted after dbg_en falls (>=1)

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
port_req  in  NUM_PORTS  per-port request; level, held until ack
port_we  in  NUM_PORTS  per-port write (1) / read (0)
port_addr  in  NUM_PORTS*ADDR_WIDTH  packed word addresses, port 0 in LSBs
port_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data
port_be  in  NUM_PORTS*NB  packed byte enables
port_ack  out  NUM_PORTS  one-cycle completion pulse per port
port_rdata  out  DATA_WIDTH  shared read data, valid only with a port_ack bit
dbg_en  in  1  debug mode request (already synchronised to clk)
dbg_req  in  1  one-cycle debug access pulse
dbg_we  in  1  debug write/read
dbg_addr  in  ADDR_WIDTH  debug word address
dbg_wdata  in  DATA_WIDTH  debug write data (full word, all bytes)
dbg_ack  out  1  one-cycle debug completion pulse
dbg_rdata  out  DATA_WIDTH  debug read data, valid with dbg_ack
dbg_active  out  1  high in DEBUG state only
cpu_hold  out  1  CPU reset hold, high in DRAIN, DEBUG, RELEASE

Behaviour:
- Reset (rst=1 at clk edge): state=NORMAL, rr pointer=0, all acks 0, port_rdata=0, dbg_rdata=0, dbg_active=0, cpu_hold=0, release counter=0. Memory contents are not cleared. Reset mid-access drops the access; no ack is issued.
- States: NORMAL, DRAIN, DEBUG, RELEASE.
- NORMAL: each cycle, at most one grant among eligible ports. Eligible = port_req high AND the port is not receiving port_ack this cycle (masks re-grant of an already-served request).
- Arbitration is round-robin: search starts at rr pointer; after a grant to port k, rr pointer = (k+1) mod NUM_PORTS.
- Grant at edge G: write updates byte lanes with be=1 (be=0 still acks, memory unchanged); read samples memory.
- port_ack[k]=1 in cycle G+1; port_rdata carries the read word in the same cycle. For writes, port_rdata is unchanged.
- Latency is 1 cycle. Per-port throughput is 1 access / 2 cycles. Aggregate throughput is 1 access/cycle when ports alternate.
- NORMAL -> DRAIN when dbg_en=1. No new grants from that edge on. An access granted in the same edge completes normally (ack next cycle).
- DRAIN -> DEBUG after one cycle: the outstanding ack has issued, so no port access is pending.
- DEBUG:
  - dbg_req sampled at edge T performs the access at T; dbg_ack=1 and dbg_rdata are valid at T+1.
  - Back-to-back dbg_req pulses are accepted every cycle.
  - port_req is ignored; no port_ack is issued.
- dbg_req outside DEBUG is ignored and dbg_ack stays 0.
- DEBUG -> RELEASE when dbg_en=0. A dbg_req sampled in the same cycle is still performed and acked.
- RELEASE: counts RELEASE_DELAY cycles with cpu_hold=1 and no grants, then enters NORMAL. rr pointer is retained.
- dbg_en re-asserted during RELEASE: go directly to DEBUG; counter cleared.
- Same-address write then read from different ports in consecutive cycles: the read returns the new data (the write completes first).
- Address arithmetic wraps naturally at ADDR_WIDTH; no out-of-range case exists.

Optional Feature:
- Macro PROG_MEM_PARITY_EN.
- When defined:
  - Memory stores one even-parity bit per byte lane, written with each byte.
  - A read whose recomputed parity mismatches sets sticky output parity_err (1 bit, reset 0, cleared only by rst).
  - Output parity_err_addr (ADDR_WIDTH) latches the first failing address.
  - Data is returned unmodified.
- When undefined: no parity storage, and parity_err/parity_err_addr ports do not exist.

Test Plan:
- NUM_PORTS=2, both ports read addr 5 (=0xA5A5A5A5) held from cycle 0: port 0 acked cycle 1, port 1 acked cycle 2, rr pointer = 0; port 0 regranted cycle 2 and acked cycle 3.
- Port 1 writes 0xDEADBEEF to addr 3 with be=4'b0011 over prior 0x11223344: subsequent read returns 0x1122BEEF.
- Port 0 read granted, dbg_en rises the same cycle: port 0 still acked next cycle; DRAIN 1 cycle; dbg_active=1 after; cpu_hold=1 from DRAIN.
- DEBUG: dbg write 0x12345678 to addr 0x3FF, next cycle dbg read 0x3FF: dbg_ack two consecutive cycles, second with dbg_rdata=0x12345678. A port_req held throughout gets no ack.
- dbg_en falls: cpu_hold stays 1 for exactly 4 cycles (RELEASE_DELAY=4); pending port_req granted on the first NORMAL cycle.
- rst asserted while a port_req is granted: no port_ack follows, all outputs 0; memory word at the written address is retained on a read after reset.
